// File: rtl/lsu_mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage_pkg
// Shared types and constants for the memory stage of the 5-stage core:
// FSM state encoding, lsu_op decode bit positions, access-size enum, the
// EX/MEM and MEM/WB pipeline payloads, and the lsu_op size-decode helper.
// ----------------------------------------------------------------------------
package lsu_mem_stage_pkg;

    localparam int DataWidth    = 32;
    localparam int RegAddrWidth = 5;
    localparam int LsuOpWidth   = 4;

    // lsu_op decode: bit3 = store, bit2 = unsigned, bit0 = half, bit1 = word
    localparam int LsuStoreBit    = 3;
    localparam int LsuUnsignedBit = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_state_t;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } lsu_size_t;

    typedef struct packed {
        logic [DataWidth-1:0]    alu_res;   // effective address for LSU ops
        logic [RegAddrWidth-1:0] rd_addr;
        logic                    rd_en;
        logic                    lsu;       // 1 = load/store instruction
        logic [LsuOpWidth-1:0]   lsu_op;
    } p_ex_mem_t;

    typedef struct packed {
        logic                    rd_en;
        logic [RegAddrWidth-1:0] rd_addr;
        logic [DataWidth-1:0]    rd_data;
    } p_mem_wb_t;

    // Half has priority over word so that op[1:0] = 2'b11 decodes as half.
    function automatic lsu_size_t lsu_size(input logic [LsuOpWidth-1:0] op);
        if (op[0]) return HALF;
        if (op[1]) return WORD;
        return BYTE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Purely combinational data-path helper for the memory stage: byte enables,
// store-data replication, load-data extraction/extension and misalignment.
//
// Ports:
//   i_lsu_op      lsu_op of the access
//   i_addr_lo     effective address bits [1:0]
//   i_store_data  rs2 value for stores
//   i_rdata       load data returned by the bus
//   o_be          byte enables
//   o_wdata       replicated store data (0 for loads)
//   o_load_data   shifted and sign/zero-extended load data
//   o_misaligned  misaligned half/word access
//
// Configuration: LSU_MISALIGN_TRAP_EN enables o_misaligned; otherwise it is
// tied 0 and misaligned halves/words are silently aligned down.
// ----------------------------------------------------------------------------
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [LsuOpWidth-1:0] i_lsu_op,
    input  logic [1:0]            i_addr_lo,
    input  logic [DataWidth-1:0]  i_store_data,
    input  logic [DataWidth-1:0]  i_rdata,
    output logic [3:0]            o_be,
    output logic [DataWidth-1:0]  o_wdata,
    output logic [DataWidth-1:0]  o_load_data,
    output logic                  o_misaligned
);

    lsu_size_t            w_size;
    logic                 w_unsigned;
    logic                 w_store;
    logic [1:0]           w_off;
    logic [DataWidth-1:0] w_shifted;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_size      = lsu_size(i_lsu_op);
        w_unsigned  = i_lsu_op[LsuUnsignedBit];
        w_store     = i_lsu_op[LsuStoreBit];
        w_off       = 2'b00;
        o_be        = 4'b1111;
        o_wdata     = '0;
        o_load_data = '0;

        // Halves ignore addr[0], words ignore addr[1:0]: this is the aligned
        // fallback when misaligned accesses are not trapped.
        case (w_size)
            BYTE:    w_off = i_addr_lo;
            HALF:    w_off = {i_addr_lo[1], 1'b0};
            default: w_off = 2'b00;
        endcase

        case (w_size)
            BYTE:    o_be = 4'b0001 << w_off;
            HALF:    o_be = 4'b0011 << w_off;
            default: o_be = 4'b1111;
        endcase

        if (w_store) begin
            case (w_size)
                BYTE:    o_wdata = {4{i_store_data[7:0]}};
                HALF:    o_wdata = {2{i_store_data[15:0]}};
                default: o_wdata = i_store_data;
            endcase
        end

        w_shifted = i_rdata >> {w_off, 3'b000};
        case (w_size)
            BYTE:    o_load_data = w_unsigned ? {24'b0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            HALF:    o_load_data = w_unsigned ? {16'b0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: o_load_data = w_shifted;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign o_misaligned = ((w_size == HALF) && i_addr_lo[0]) ||
                          ((w_size == WORD) && (i_addr_lo != 2'b00));
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// lsu_mem_stage
// Memory stage: takes the EX/MEM payload, runs loads/stores over a
// req/gnt/rvalid data bus and produces the MEM/WB payload. EX is stalled
// (ex_ready_o low) while a bus transaction is outstanding.
//
// Ports:
//   clk, rst           core clock, asynchronous active-high reset
//   ex_valid_i         EX/MEM payload valid
//   ex_mem_i           EX/MEM payload (alu_res = address for LSU ops)
//   store_data_i       rs2 value for stores
//   ex_ready_o         stage can accept (FSM in IDLE)
//   dmem_*             data-memory bus (req/we/addr/be/wdata out,
//                      gnt/rvalid/rdata in)
//   wb_valid_o         one-cycle MEM/WB valid pulse per instruction
//   mem_wb_o           MEM/WB payload
//   lsu_misaligned_o   misaligned-access pulse
//
// Configuration: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no bus request, lsu_misaligned_o pulse, wb with rd_en = 0).
// ----------------------------------------------------------------------------
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid_i,
    input  p_ex_mem_t            ex_mem_i,
    input  logic [DataWidth-1:0] store_data_i,
    output logic                 ex_ready_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [31:0]          dmem_addr_o,
    output logic [3:0]           dmem_be_o,
    output logic [31:0]          dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [31:0]          dmem_rdata_i,
    output logic                 wb_valid_o,
    output p_mem_wb_t            mem_wb_o,
    output logic                 lsu_misaligned_o
);

    lsu_state_t              r_state;
    logic [LsuOpWidth-1:0]   r_op;
    logic [1:0]              r_off;
    logic [RegAddrWidth-1:0] r_rd_addr;
    logic                    r_rd_en;
    logic                    r_req;
    logic                    r_we;
    logic [31:0]             r_addr;
    logic [3:0]              r_be;
    logic [31:0]             r_wdata;
    logic                    r_wb_valid;
    p_mem_wb_t               r_mem_wb;
    logic                    r_misaligned;

    logic                    w_idle;
    logic [LsuOpWidth-1:0]   w_op;
    logic [1:0]              w_off;
    logic [3:0]              w_be;
    logic [DataWidth-1:0]    w_wdata;
    logic [DataWidth-1:0]    w_load_data;
    logic                    w_misaligned;

    assign w_idle = (r_state == IDLE);

    // One aligner serves both directions: in IDLE it shapes the incoming
    // store/bus fields, in WAIT it extracts load data for the latched op.
    assign w_op  = w_idle ? ex_mem_i.lsu_op       : r_op;
    assign w_off = w_idle ? ex_mem_i.alu_res[1:0] : r_off;

    lsu_align u_align (
        .i_lsu_op     (w_op),
        .i_addr_lo    (w_off),
        .i_store_data (store_data_i),
        .i_rdata      (dmem_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_off        <= '0;
            r_rd_addr    <= '0;
            r_rd_en      <= 1'b0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_wb_valid   <= 1'b0;
            r_mem_wb     <= '0;
            r_misaligned <= 1'b0;
        end else begin
            // Pulses by default; rd_en must never be seen high without wb_valid.
            r_wb_valid      <= 1'b0;
            r_misaligned    <= 1'b0;
            r_mem_wb.rd_en  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (ex_valid_i) begin
                        if (!ex_mem_i.lsu) begin
                            r_wb_valid <= 1'b1;
                            r_mem_wb   <= '{rd_en:   ex_mem_i.rd_en && (ex_mem_i.rd_addr != '0),
                                            rd_addr: ex_mem_i.rd_addr,
                                            rd_data: ex_mem_i.alu_res};
                        end else if (w_misaligned) begin
                            r_wb_valid   <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_op      <= ex_mem_i.lsu_op;
                            r_off     <= ex_mem_i.alu_res[1:0];
                            r_rd_addr <= ex_mem_i.rd_addr;
                            r_rd_en   <= ex_mem_i.rd_en;
                            r_req     <= 1'b1;
                            r_we      <= ex_mem_i.lsu_op[LsuStoreBit];
                            r_addr    <= {ex_mem_i.alu_res[31:2], 2'b00};
                            r_be      <= w_be;
                            r_wdata   <= w_wdata;
                            r_state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_wb_valid <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        r_wb_valid <= 1'b1;
                        r_mem_wb   <= '{rd_en:   r_rd_en && (r_rd_addr != '0),
                                        rd_addr: r_rd_addr,
                                        rd_data: w_load_data};
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ex_ready_o       = w_idle;
    assign dmem_req_o       = r_req;
    assign dmem_we_o        = r_we;
    assign dmem_addr_o      = r_addr;
    assign dmem_be_o        = r_be;
    assign dmem_wdata_o     = r_wdata;
    assign wb_valid_o       = r_wb_valid;
    assign mem_wb_o         = r_mem_wb;
    assign lsu_misaligned_o = r_misaligned;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_stage
// Self-checking bench for lsu_mem_stage. Expected MEM/WB payloads are queued
// when an instruction is issued and compared when wb_valid_o is observed.
// ----------------------------------------------------------------------------
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid_i = 1'b0;
    p_ex_mem_t   ex_mem_i = '0;
    logic [31:0] store_data_i = '0;
    logic        ex_ready_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        wb_valid_o;
    p_mem_wb_t   mem_wb_o;
    logic        lsu_misaligned_o;

    int checks = 0;
    int errors = 0;
    p_mem_wb_t sb_q[$];

    always #5 clk = ~clk;

    lsu_mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid_i       (ex_valid_i),
        .ex_mem_i         (ex_mem_i),
        .store_data_i     (store_data_i),
        .ex_ready_o       (ex_ready_o),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_gnt_i       (dmem_gnt_i),
        .dmem_rvalid_i    (dmem_rvalid_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .wb_valid_o       (wb_valid_o),
        .mem_wb_o         (mem_wb_o),
        .lsu_misaligned_o (lsu_misaligned_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops one expected payload per observed writeback pulse.
    task automatic sb_monitor();
        p_mem_wb_t exp_wb;
        forever begin
            @(negedge clk);
            if (!rst && wb_valid_o) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_wb: got wb_valid_o=1 rd=%0d data=%h, expected no writeback",
                             mem_wb_o.rd_addr, mem_wb_o.rd_data);
                end else begin
                    exp_wb = sb_q.pop_front();
                    if (mem_wb_o.rd_en !== exp_wb.rd_en) begin
                        errors++;
                        $display("FAIL sb_rd_en: got %b expected %b", mem_wb_o.rd_en, exp_wb.rd_en);
                    end
                    if (exp_wb.rd_en) begin
                        checks++;
                        if (mem_wb_o.rd_addr !== exp_wb.rd_addr || mem_wb_o.rd_data !== exp_wb.rd_data) begin
                            errors++;
                            $display("FAIL sb_payload: got rd=%0d data=%h expected rd=%0d data=%h",
                                     mem_wb_o.rd_addr, mem_wb_o.rd_data, exp_wb.rd_addr, exp_wb.rd_data);
                        end
                    end
                end
            end
        end
    endtask

    // Presents one instruction and lets the next edge accept it.
    task automatic issue(input string name, input logic lsu, input logic [3:0] op,
                         input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] sdata);
        ex_valid_i   = 1'b1;
        ex_mem_i     = '{alu_res: addr, rd_addr: rd, rd_en: 1'b1, lsu: lsu, lsu_op: op};
        store_data_i = sdata;
        checks++;
        if (ex_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_issue: got %b expected 1", name, ex_ready_o);
        end
        tick();
        ex_valid_i = 1'b0;
    endtask

    // Load with immediate gnt and rvalid in the cycle after gnt.
    task automatic do_load(input string name, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data, input logic [4:0] rd);
        sb_q.push_back('{rd_en: (rd != 5'd0), rd_addr: rd, rd_data: exp_data});
        issue(name, 1'b1, op, addr, rd, 32'h0);
        checks++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, ex_ready_o} !==
            {1'b1, 1'b0, exp_addr, exp_be, 1'b0}) begin
            errors++;
            $display("FAIL %s bus: got req=%b we=%b addr=%h be=%b ready=%b expected req=1 we=0 addr=%h be=%b ready=0",
                     name, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, ex_ready_o, exp_addr, exp_be);
        end
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        checks++;
        if ({dmem_req_o, ex_ready_o, wb_valid_o} !== 3'b000) begin
            errors++;
            $display("FAIL %s wait_state: got req=%b ready=%b wb=%b expected 0 0 0",
                     name, dmem_req_o, ex_ready_o, wb_valid_o);
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        tick();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        checks++;
        if ({wb_valid_o, ex_ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL %s wb_timing: got wb=%b ready=%b expected 1 1", name, wb_valid_o, ex_ready_o);
        end
    endtask

    // Store with gnt withheld for gnt_delay cycles after req rises.
    task automatic do_store(input string name, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata, input int gnt_delay);
        sb_q.push_back('{rd_en: 1'b0, rd_addr: 5'd0, rd_data: 32'h0});
        issue(name, 1'b1, op, addr, 5'd3, sdata);
        for (int i = 0; i <= gnt_delay; i++) begin
            checks++;
            if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, ex_ready_o, wb_valid_o} !==
                {1'b1, 1'b1, exp_addr, exp_be, exp_wdata, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s bus_cycle%0d: got req=%b we=%b addr=%h be=%b wdata=%h ready=%b wb=%b expected 1 1 %h %b %h 0 0",
                         name, i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                         ex_ready_o, wb_valid_o, exp_addr, exp_be, exp_wdata);
            end
            if (i == gnt_delay) dmem_gnt_i = 1'b1;
            tick();
        end
        dmem_gnt_i = 1'b0;
        checks++;
        if ({dmem_req_o, wb_valid_o, ex_ready_o} !== 3'b011) begin
            errors++;
            $display("FAIL %s after_gnt: got req=%b wb=%b ready=%b expected 0 1 1",
                     name, dmem_req_o, wb_valid_o, ex_ready_o);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ex_ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
             wb_valid_o, mem_wb_o, lsu_misaligned_o} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 38'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got ready=%b req=%b we=%b addr=%h be=%b wdata=%h wb=%b mem_wb=%h mis=%b expected ready=1, rest 0",
                     ex_ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                     wb_valid_o, mem_wb_o, lsu_misaligned_o);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({ex_ready_o, wb_valid_o, dmem_req_o} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: got ready=%b wb=%b req=%b expected 1 0 0",
                     ex_ready_o, wb_valid_o, dmem_req_o);
        end
    endtask

    task automatic test_loads();
        do_load("lw",     OP_LW,  32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF, 5'd1);
        do_load("lb",     OP_LB,  32'h103, 32'h80FFFFFF, 32'h100, 4'b1000, 32'hFFFFFF80, 5'd2);
        do_load("lbu",    OP_LBU, 32'h103, 32'h80FFFFFF, 32'h100, 4'b1000, 32'h00000080, 5'd3);
        do_load("lhu",    OP_LHU, 32'h102, 32'hABCD1234, 32'h100, 4'b1100, 32'h0000ABCD, 5'd4);
        do_load("lh_rd0", OP_LH,  32'h200, 32'h00008765, 32'h200, 4'b0011, 32'hFFFF8765, 5'd0);
    endtask

    task automatic test_stores();
        do_store("sb", OP_SB, 32'h201, 32'h12345678, 32'h200, 4'b0010, 32'h78787878, 3);
        do_store("sh", OP_SH, 32'h302, 32'hAAAA5678, 32'h300, 4'b1100, 32'h56785678, 0);
        do_store("sw", OP_SW, 32'h404, 32'h13579BDF, 32'h404, 4'b1111, 32'h13579BDF, 0);
    endtask

    task automatic test_back_to_back();
        sb_q.push_back('{rd_en: 1'b1, rd_addr: 5'd7, rd_data: 32'h5});
        sb_q.push_back('{rd_en: 1'b0, rd_addr: 5'd0, rd_data: 32'h0});
        ex_valid_i = 1'b1;
        ex_mem_i   = '{alu_res: 32'h5, rd_addr: 5'd7, rd_en: 1'b1, lsu: 1'b0, lsu_op: 4'h0};
        tick();
        ex_mem_i   = '{alu_res: 32'h9, rd_addr: 5'd0, rd_en: 1'b1, lsu: 1'b0, lsu_op: 4'h0};
        checks++;
        if ({wb_valid_o, ex_ready_o} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_first: got wb=%b ready=%b expected 1 1", wb_valid_o, ex_ready_o);
        end
        tick();
        ex_valid_i = 1'b0;
        checks++;
        if (wb_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got wb=%b expected 1", wb_valid_o);
        end
        tick();
        checks++;
        if (wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got wb=%b expected 0", wb_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        issue("rst_mid", 1'b1, OP_LW, 32'h400, 5'd5, 32'h0);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        checks++;
        if ({ex_ready_o, dmem_req_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_wait: got ready=%b req=%b expected 0 0", ex_ready_o, dmem_req_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ex_ready_o, dmem_req_o, wb_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_abort: got ready=%b req=%b wb=%b expected 1 0 0",
                     ex_ready_o, dmem_req_o, wb_valid_o);
        end
        tick();
        rst           = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h55AA55AA;
        tick();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        checks++;
        if ({wb_valid_o, ex_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_late_rvalid: got wb=%b ready=%b expected 0 1", wb_valid_o, ex_ready_o);
        end
        tick();
        checks++;
        if (wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got wb=%b expected 0", wb_valid_o);
        end
    endtask

    task automatic test_misaligned();
`ifdef LSU_MISALIGN_TRAP_EN
        sb_q.push_back('{rd_en: 1'b0, rd_addr: 5'd0, rd_data: 32'h0});
        issue("lw_mis", 1'b1, OP_LW, 32'h102, 5'd9, 32'h0);
        checks++;
        if ({dmem_req_o, lsu_misaligned_o, wb_valid_o, ex_ready_o} !== 4'b0111) begin
            errors++;
            $display("FAIL lw_mis_trap: got req=%b mis=%b wb=%b ready=%b expected 0 1 1 1",
                     dmem_req_o, lsu_misaligned_o, wb_valid_o, ex_ready_o);
        end
        tick();
        checks++;
        if ({dmem_req_o, lsu_misaligned_o, wb_valid_o} !== 3'b000) begin
            errors++;
            $display("FAIL lw_mis_pulse: got req=%b mis=%b wb=%b expected 0 0 0",
                     dmem_req_o, lsu_misaligned_o, wb_valid_o);
        end
`else
        do_load("lw_mis", OP_LW, 32'h102, 32'hCAFEF00D, 32'h100, 4'b1111, 32'hCAFEF00D, 5'd9);
        do_load("lh_mis", OP_LH, 32'h103, 32'h80011234, 32'h100, 4'b1100, 32'hFFFF8001, 5'd10);
        checks++;
        if (lsu_misaligned_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_tied: got %b expected 0", lsu_misaligned_o);
        end
`endif
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_loads();
        test_stores();
        test_back_to_back();
        test_reset_mid();
        test_misaligned();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending writebacks expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory stage of the 5-stage core: consumes the EX/MEM payload (`p_ex_mem_t`), executes loads and stores on the data-memory bus with a req/gnt/rvalid handshake, and produces the MEM/WB payload (`p_mem_wb_t`). It aligns addresses, generates byte enables, replicates store data and sign- or zero-extends load data. It stalls EX while a memory transaction is outstanding.

## Interface
- `DataWidth`, 32, register/data width (from `param_defs`)
- `RegAddrWidth`, 5, register address width
- `LsuOpWidth`, 4, width of the `lsu_op` field
- `clk`  in  1  core clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `ex_valid_i`  in  1  EX/MEM payload valid
- `ex_mem_i`  in  `p_ex_mem_t`  EX result; `alu_res` is the effective address for LSU ops
- `store_data_i`  in  DataWidth  rs2 value for stores
- `ex_ready_o`  out  1  stage can accept; low stalls EX
- `dmem_req_o`  out  1  bus request
- `dmem_we_o`  out  1  1 = store
- `dmem_addr_o`  out  32  word-aligned address
- `dmem_be_o`  out  4  byte enables
- `dmem_wdata_o`  out  32  store data
- `dmem_gnt_i`  in  1  request accepted
- `dmem_rvalid_i`  in  1  load data valid
- `dmem_rdata_i`  in  32  load data
- `wb_valid_o`  out  1  MEM/WB payload valid, one-cycle pulse per instruction
- `mem_wb_o`  out  `p_mem_wb_t`  writeback payload
- `lsu_misaligned_o`  out  1  misaligned-access pulse (only with `LSU_MISALIGN_TRAP_EN`)

## Operation
- FSM states: IDLE, REQ, WAIT. `ex_ready_o` = (state == IDLE).
- An instruction is accepted on `ex_valid_i && ex_ready_o`.
- Non-LSU (`lsu == 0`): stay in IDLE. Register `{rd_en, rd_addr, alu_res}` into `mem_wb_o` and pulse `wb_valid_o`.
- LSU: latch the op, address, store data and rd fields, then go to REQ.
- REQ: hold `dmem_req_o` high with stable address, be, we and wdata until `dmem_gnt_i` is seen.
  - Store with gnt: go to IDLE, pulse `wb_valid_o` with `rd_en = 0`.
  - Load with gnt: go to WAIT.
- WAIT: on `dmem_rvalid_i`, register the extracted data into `rd_data`, pulse `wb_valid_o`, go to IDLE.
- `lsu_op` decode:
  - bit3 = store.
  - bit2 = unsigned.
  - bit0 = 1 selects half; otherwise bit1 = 1 selects word; otherwise byte.
- Address and byte enables:
  - `dmem_addr_o = {addr[31:2], 2'b00}`.
  - Byte: `be = 4'b0001 << addr[1:0]`.
  - Half: `be = 4'b0011 << {addr[1], 1'b0}`.
  - Word: `be = 4'b1111`.
- Store data: byte replicated ×4, half replicated ×2, word unchanged.
- Load data: `rdata >> (8*offset)`, then sign-extend (signed) or zero-extend (unsigned) from 8 or 16 bits; words pass through.
- `mem_wb_o.rd_en` is forced 0 when `rd_addr == 0`, when the op is a store, or when `wb_valid_o == 0`.
- `dmem_rvalid_i` outside WAIT and `dmem_gnt_i` outside REQ are ignored.

## Timing
- Reset values: all outputs 0 except `ex_ready_o = 1`; state = IDLE.
- Non-LSU op accepted in cycle N: `wb_valid_o` in N+1.
- `dmem_req_o` is registered: an LSU op accepted in N raises req in N+1.
- gnt in the same cycle as req is allowed.
- Store: `wb_valid_o` in the cycle after gnt. Minimum latency is 2 cycles.
- Load: rvalid may arrive no earlier than the cycle after gnt. `wb_valid_o` follows in the cycle after rvalid. Minimum latency is 3 cycles.
- Back-to-back non-LSU ops sustain 1 op/cycle.
- The next op is accepted in the same cycle that the FSM is back in IDLE.
- Reset mid-operation (REQ/WAIT): the FSM immediately drops to IDLE and `dmem_req_o` clears.
  - An rvalid arriving after reset is ignored.
  - No `wb_valid_o` is produced for the aborted op.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined: a half access with `addr[0] = 1`, or a word access with `addr[1:0] != 0`, issues no bus request.
  - `lsu_misaligned_o` pulses for one cycle (N+1).
  - `wb_valid_o` pulses with `rd_en = 0`.
  - The FSM stays in IDLE.
- Undefined:
  - `lsu_misaligned_o` is tied 0.
  - Misaligned half accesses drop `addr[0]`; misaligned word accesses drop `addr[1:0]`.
  - The access then proceeds aligned.

## Structure
- The shared package holds:
  - the `lsu_state_t` enum (IDLE/REQ/WAIT);
  - the decode constants `LsuStoreBit = 3`, `LsuUnsignedBit = 2`;
  - the `lsu_size_t` enum (BYTE/HALF/WORD);
  - existing `p_ex_mem_t` / `p_mem_wb_t`.
- One sub-module: `lsu_align`, purely combinational. It takes `lsu_op`, `addr[1:0]`, store data and rdata, and produces be, replicated wdata, extended load data and the misaligned flag.

## Test plan
- `LW @0x100`, rdata `0xDEADBEEF`, gnt immediate, rvalid next cycle -> be `1111`, addr `0x100`, `rd_data = 0xDEADBEEF`, `wb_valid_o` 3 cycles after accept.
- `LB @0x103`, rdata `0x80FF_FFFF` -> be `1000`, `rd_data = 0xFFFFFF80`. `LBU` with the same stimulus -> `0x00000080`.
- `LHU @0x102`, rdata `0xABCD1234` -> be `1100`, `rd_data = 0x0000ABCD`.
- `SB @0x201`, `store_data_i = 0x12345678`, gnt withheld 3 cycles -> req, addr and be (`0010`) stable until gnt, wdata `0x78787878`, `ex_ready_o` low throughout, `wb_valid_o` with `rd_en = 0` the cycle after gnt.
- `ADD` result `0x5` to x7, followed by `ADD` to x0 -> consecutive `wb_valid_o` pulses. The first carries rd 7 with `rd_data` 5 and `rd_en = 1`; the second carries `rd_en = 0`.
- Load in WAIT, assert `rst` for 1 cycle, then rvalid -> `ex_ready_o = 1`, no `wb_valid_o`.
- With `LSU_MISALIGN_TRAP_EN`: `LW @0x102` -> no req, `lsu_misaligned_o` pulses once.
